// File: rtl/rv32e_wb_queue_pkg.sv
// Shared constants for the RV32E writeback queue: source-select encodings
// and the architectural register count.
package rv32e_wb_queue_pkg;

  localparam int NREG_RV32E = 16;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_LSU = 2'd1,
    WB_SEL_CSR = 2'd2,
    WB_SEL_MDU = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/rv32e_wb_queue_if.sv
// Bus between the LSU stage / commit side and the writeback queue.
interface rv32e_wb_queue_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 64
);
  import rv32e_wb_queue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_wen;
  logic [ADDR_W-1:0] in_rd;
  logic [1:0]        in_sel;
  logic [XLEN-1:0]   in_alu;
  logic [XLEN-1:0]   in_lsu;
  logic [XLEN-1:0]   in_csr;
  logic [XLEN-1:0]   in_mdu;
  logic              flush;
  logic              out_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]   fwd_data;
  logic              retire_pulse;
  logic [CNT_W-1:0]  instret;
  logic              err_illegal_rd;

  modport master (
    output in_valid, in_wen, in_rd, in_sel, in_alu, in_lsu, in_csr, in_mdu,
           flush, out_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           retire_pulse, instret, err_illegal_rd
  );

  modport slave (
    input  in_valid, in_wen, in_rd, in_sel, in_alu, in_lsu, in_csr, in_mdu,
           flush, out_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
           retire_pulse, instret, err_illegal_rd
  );

endinterface

// File: rtl/rv32e_wb_queue_fifo.sv
// Synchronous FIFO with flush; storage is cleared on reset so the head
// reads as zero out of reset.
module rv32e_sync_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic [PTR_W:0] count,
  output logic           empty,
  output logic           full
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32e_wb_queue.sv
// Writeback queue: resolves the result source at push time, buffers
// instructions, and drives register-file write, forwarding and retire count.
module rv32e_wb_queue
  import rv32e_wb_queue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = NREG_RV32E,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 64
) (
  input logic                clk,
  input logic                rst_n,
  rv32e_wb_queue_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = 1 + ADDR_W + XLEN;

  logic [XLEN-1:0]   mux_data;
  logic [EW-1:0]     head;
  logic [PTR_W:0]    count;
  logic              empty, full, push, pop;
  logic              head_wen;
  logic [ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic              rd_legal, rd_nz;
  logic [CNT_W-1:0]  instret;

  always_comb begin
    mux_data = bus.in_alu;
    case (wb_sel_e'(bus.in_sel))
      WB_SEL_ALU: mux_data = bus.in_alu;
      WB_SEL_LSU: mux_data = bus.in_lsu;
      WB_SEL_CSR: mux_data = bus.in_csr;
      WB_SEL_MDU: mux_data = bus.in_mdu;
      default:    mux_data = bus.in_alu;
    endcase
  end

  // Ready depends only on registered occupancy: a full queue refuses a
  // push even when it pops in the same cycle.
  assign bus.in_ready = !full;
  assign push = bus.in_valid & !full & !bus.flush;
  assign pop  = !empty & bus.out_ready & !bus.flush;

  rv32e_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   ({bus.in_wen, bus.in_rd, mux_data}),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign {head_wen, head_rd, head_data} = head;
  assign rd_legal = ({1'b0, head_rd} < (ADDR_W+1)'(NREG));
  assign rd_nz    = (head_rd != '0);

  assign bus.rf_we          = pop & head_wen & rd_nz & rd_legal;
  assign bus.rf_waddr       = head_rd;
  assign bus.rf_wdata       = head_data;
  assign bus.retire_pulse   = pop;
  assign bus.err_illegal_rd = pop & head_wen & !rd_legal;

  assign bus.fwd_valid = !empty & head_wen & rd_nz & rd_legal & !bus.flush;
  assign bus.fwd_addr  = head_rd;
  assign bus.fwd_data  = head_data;

  always_ff @(posedge clk) begin
    if (!rst_n)   instret <= '0;
    else if (pop) instret <= instret + 1'b1;
  end
  assign bus.instret = instret;

endmodule
